// File: rtl/led_code_sequencer_pkg.sv
// Shared types and helpers for the LED select-code sequencer.
// The state enum, code width and wrap arithmetic are defined once here.
package led_seq_pkg;

    localparam int CODE_W = 3;

    typedef enum logic {
        RUN   = 1'b0,
        PAUSE = 1'b1
    } seq_state_t;

    // Next code in the current direction, wrapping between code_max and 0.
    function automatic logic [CODE_W-1:0] next_code(
        input logic [CODE_W-1:0] cur,
        input logic              down,
        input logic [CODE_W-1:0] code_max
    );
        if (down)
            return (cur == '0) ? code_max : cur - 1'b1;
        return (cur == code_max) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/led_code_sequencer_key_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a
// single-cycle press pulse on an accepted 1->0 transition of the key level.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync     <= 2'b11;
            stable   <= 1'b1;
            stable_d <= 1'b1;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync     <= {sync[0], key_n};
            stable_d <= stable;
            // Pulse only on the falling edge of the accepted level.
            press    <= stable_d & ~stable;
            if (sync[1] == stable)
                cnt <= '0;
            else if (cnt == CNT_LAST) begin
                stable <= ~stable;
                cnt    <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_code_sequencer.sv
// Prescaled 3-bit LED select-code generator with run/pause and direction
// buttons; feeds the downstream 3-to-8 decoder (code[2]=a, code[1]=b, code[0]=c).
module led_code_sequencer
    import led_seq_pkg::*;
#(
    parameter int TICK_DIV        = 62500000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CODE_MAX        = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_run_n,
    input  logic              key_dir_n,
    output logic [CODE_W-1:0] code,
    output logic              code_stb,
    output logic              running,
    output logic              dir_down
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [CODE_W-1:0] CODE_LAST = CODE_W'(CODE_MAX);

    logic run_press;
    logic dir_press;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_run (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_run_n),
        .press (run_press)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_dir (
        .clk   (clk),
        .rst   (rst),
        .key_n (key_dir_n),
        .press (dir_press)
    );

    seq_state_t        state, state_nxt;
    logic [PRE_W-1:0]  pre, pre_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic              stb_nxt;
    logic              dir_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            pre      <= '0;
            code     <= '0;
            code_stb <= 1'b0;
            dir_down <= 1'b0;
        end else begin
            state    <= state_nxt;
            pre      <= pre_nxt;
            code     <= code_nxt;
            code_stb <= stb_nxt;
            dir_down <= dir_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pre_nxt   = pre;
        code_nxt  = code;
        stb_nxt   = 1'b0;
        // A step in the same cycle still uses the old dir_down below.
        dir_nxt   = dir_down ^ dir_press;
        unique case (state)
            RUN: begin
                if (run_press) begin
                    // Pausing wins over a step that falls in the same cycle.
                    state_nxt = PAUSE;
                    pre_nxt   = '0;
                end else if (pre == PRE_LAST) begin
                    pre_nxt  = '0;
                    code_nxt = next_code(code, dir_down, CODE_LAST);
                    stb_nxt  = 1'b1;
                end else begin
                    pre_nxt = pre + 1'b1;
                end
            end
            PAUSE: begin
                pre_nxt = '0;
                if (run_press)
                    state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    assign running = (state == RUN);

endmodule
